// File: rtl/mux_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : mux_arbiter_if
//  Description : Requester, downstream and status bundle for mux_arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
interface mux_arbiter_if #(
    parameter int DATA_W = 136
);
    logic [2:0]        in_valid;
    logic [2:0]        in_last;
    logic [DATA_W-1:0] in_data_1;
    logic [DATA_W-1:0] in_data_2;
    logic [DATA_W-1:0] in_data_3;
    logic [2:0]        in_ready;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_last;
    logic              out_ready;
    logic [1:0]        mux_sel;
    logic              busy;
    logic              overrun;

    modport master (
        output in_valid, in_last, in_data_1, in_data_2, in_data_3, out_ready,
        input  in_ready, out_valid, out_data, out_last, mux_sel, busy, overrun
    );

    modport slave (
        input  in_valid, in_last, in_data_1, in_data_2, in_data_3, out_ready,
        output in_ready, out_valid, out_data, out_last, mux_sel, busy, overrun
    );
endinterface
`default_nettype wire

// File: rtl/mux_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mux_arbiter
//  Description : Round-robin burst arbiter for a 3-input datapath mux with a
//                registered valid/ready output stage and beat-limit release.
//  Revision    : 1.0 - initial release
// ============================================================================
module mux_arbiter #(
    parameter int DATA_W    = 136,
    parameter int MAX_BEATS = 16
) (
    input  wire logic     clk,
    input  wire logic     rst_n,
    mux_arbiter_if.slave  bus
);
    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_t;

    localparam logic [7:0] c_LAST_CNT = 8'(MAX_BEATS - 1);

    state_t            state_q, state_d;
    logic [1:0]        mux_sel_q, mux_sel_d;
    logic [1:0]        last_grant_q, last_grant_d;
    logic [7:0]        beat_cnt_q, beat_cnt_d;
    logic              out_valid_q, out_valid_d;
    logic              out_last_q, out_last_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              overrun_q, overrun_d;

    logic              w_can_load, w_sel_valid, w_sel_last, w_accept;
    logic              w_at_limit, w_end;
    logic [DATA_W-1:0] w_sel_data;
    logic [2:0]        w_in_ready;
    logic [1:0]        w_c1, w_c2, w_c3, w_winner;

    assign w_can_load = ~out_valid_q | bus.out_ready;
    assign w_at_limit = (beat_cnt_q == c_LAST_CNT);

    always_comb begin
        w_sel_valid = bus.in_valid[2];
        w_sel_last  = bus.in_last[2];
        w_sel_data  = bus.in_data_3;
        w_in_ready  = 3'b000;
        case (mux_sel_q)
            2'd0: begin
                w_sel_valid = bus.in_valid[0];
                w_sel_last  = bus.in_last[0];
                w_sel_data  = bus.in_data_1;
                w_in_ready  = 3'b001;
            end
            2'd1: begin
                w_sel_valid = bus.in_valid[1];
                w_sel_last  = bus.in_last[1];
                w_sel_data  = bus.in_data_2;
                w_in_ready  = 3'b010;
            end
            default: w_in_ready = 3'b100;
        endcase
        if (!((state_q == ST_BURST) && w_can_load)) begin
            w_in_ready = 3'b000;
        end
    end

    assign w_accept = (state_q == ST_BURST) & w_sel_valid & w_can_load;
    assign w_end    = w_accept & (w_sel_last | w_at_limit);

    // Search order starts just after the previous winner.
    always_comb begin
        case (last_grant_q)
            2'd0:    begin w_c1 = 2'd1; w_c2 = 2'd2; w_c3 = 2'd0; end
            2'd1:    begin w_c1 = 2'd2; w_c2 = 2'd0; w_c3 = 2'd1; end
            default: begin w_c1 = 2'd0; w_c2 = 2'd1; w_c3 = 2'd2; end
        endcase
        if (bus.in_valid[w_c1])      w_winner = w_c1;
        else if (bus.in_valid[w_c2]) w_winner = w_c2;
        else                         w_winner = w_c3;
    end

    always_comb begin
        state_d      = state_q;
        mux_sel_d    = mux_sel_q;
        last_grant_d = last_grant_q;
        beat_cnt_d   = beat_cnt_q;
        out_valid_d  = out_valid_q;
        out_last_d   = out_last_q;
        out_data_d   = out_data_q;
        overrun_d    = 1'b0;

        if (w_accept) begin
            out_valid_d = 1'b1;
            out_data_d  = w_sel_data;
            out_last_d  = w_sel_last | w_at_limit;
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (|bus.in_valid) begin
                    state_d    = ST_BURST;
                    mux_sel_d  = w_winner;
                    beat_cnt_d = 8'd0;
                end
            end
            default: begin
                if (w_end) begin
                    state_d      = ST_IDLE;
                    last_grant_d = mux_sel_q;
                    beat_cnt_d   = 8'd0;
                    overrun_d    = ~w_sel_last;
                end else if (w_accept) begin
                    beat_cnt_d = beat_cnt_q + 8'd1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            mux_sel_q    <= 2'd0;
            last_grant_q <= 2'd2;
            beat_cnt_q   <= 8'd0;
            out_valid_q  <= 1'b0;
            out_last_q   <= 1'b0;
            out_data_q   <= '0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            mux_sel_q    <= mux_sel_d;
            last_grant_q <= last_grant_d;
            beat_cnt_q   <= beat_cnt_d;
            out_valid_q  <= out_valid_d;
            out_last_q   <= out_last_d;
            out_data_q   <= out_data_d;
            overrun_q    <= overrun_d;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_last  = out_last_q;
    assign bus.mux_sel   = mux_sel_q;
    assign bus.busy      = (state_q == ST_BURST);
    assign bus.overrun   = overrun_q;
endmodule
`default_nettype wire

// File: tb/tb_mux_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mux_arbiter
//  Description : Self-checking bench for mux_arbiter against a cycle model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mux_arbiter;
    localparam int DATA_W    = 136;
    localparam int MAX_BEATS = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic v1 = 0, v2 = 0, v3 = 0, l1 = 0, l2 = 0, l3 = 0, ordy = 1;
    logic [DATA_W-1:0] d1 = '0, d2 = '0, d3 = '0;

    mux_arbiter_if #(.DATA_W(DATA_W)) bus ();
    assign bus.in_valid  = {v3, v2, v1};
    assign bus.in_last   = {l3, l2, l1};
    assign bus.in_data_1 = d1;
    assign bus.in_data_2 = d2;
    assign bus.in_data_3 = d3;
    assign bus.out_ready = ordy;

    mux_arbiter #(.DATA_W(DATA_W), .MAX_BEATS(MAX_BEATS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [DATA_W:0] act, input logic [DATA_W:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference model: owner = granted source (-1 when idle), beats counted from 1.
    int                m_owner, m_lg, m_cnt;
    logic [1:0]        m_sel;
    logic              m_ov, m_oval, m_olast;
    logic [DATA_W-1:0] m_odata;

    function automatic logic [DATA_W-1:0] src_data(input int s);
        case (s)
            0:       return d1;
            1:       return d2;
            default: return d3;
        endcase
    endfunction

    task automatic m_reset();
        m_owner = -1; m_lg = 2; m_cnt = 0; m_sel = 2'd0;
        m_ov = 0; m_oval = 0; m_olast = 0; m_odata = '0;
    endtask

    task automatic m_step();
        logic [2:0] vin;
        logic [2:0] lin;
        vin  = bus.in_valid;
        lin  = bus.in_last;
        m_ov = 0;
        if (m_owner < 0) begin
            if (m_oval && ordy) m_oval = 0;
            for (int k = 1; k <= 3; k++) begin
                if (m_owner < 0 && vin[(m_lg + k) % 3]) m_owner = (m_lg + k) % 3;
            end
            if (m_owner >= 0) begin
                m_sel = 2'(m_owner);
                m_cnt = 0;
            end
        end else if ((!m_oval || ordy) && vin[m_owner]) begin
            m_oval  = 1;
            m_odata = src_data(m_owner);
            m_cnt++;
            m_olast = lin[m_owner] || (m_cnt == MAX_BEATS);
            if (m_olast) begin
                m_ov    = !lin[m_owner];
                m_lg    = m_owner;
                m_owner = -1;
            end
        end else if (ordy) begin
            m_oval = 0;
        end
    endtask

    initial begin
        m_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) m_reset();
            else        m_step();
        end
    end

    logic [DATA_W:0] out_log[$];
    logic [1:0]      grant_log[$];
    int              ov_count  = 0;
    int              acc_count = 0;
    logic            prev_busy = 0;

    initial begin
        forever begin
            logic [2:0] er;
            @(negedge clk);
            if (!rst_n) begin
                prev_busy = 0;
            end else begin
                er = 3'b000;
                if (m_owner >= 0 && (!m_oval || ordy)) er[m_owner] = 1'b1;
                chk("in_ready",  {134'd0, bus.in_ready}, {134'd0, er});
                chk("mux_sel",   {135'd0, bus.mux_sel},  {135'd0, m_sel});
                chk("busy",      {136'd0, bus.busy},     {136'd0, m_owner >= 0});
                chk("overrun",   {136'd0, bus.overrun},  {136'd0, m_ov});
                chk("out_valid", {136'd0, bus.out_valid}, {136'd0, m_oval});
                if (m_oval) begin
                    chk("out_data", {1'b0, bus.out_data}, {1'b0, m_odata});
                    chk("out_last", {136'd0, bus.out_last}, {136'd0, m_olast});
                end
                if (bus.out_valid && ordy) out_log.push_back({bus.out_last, bus.out_data});
                if (bus.busy && !prev_busy) grant_log.push_back(bus.mux_sel);
                prev_busy = bus.busy;
                if (bus.overrun) ov_count++;
                if (|(bus.in_valid & bus.in_ready)) acc_count++;
            end
        end
    end

    task automatic set_src(input int s, input logic v, input logic [DATA_W-1:0] d, input logic l);
        case (s)
            0:       begin v1 = v; d1 = d; l1 = l; end
            1:       begin v2 = v; d2 = d; l2 = l; end
            default: begin v3 = v; d3 = d; l3 = l; end
        endcase
    endtask

    task automatic send_burst(input int s, input int n, input logic [DATA_W-1:0] base,
                              input bit last_end, input int gap_at, input int gap_len);
        for (int i = 0; i < n; i++) begin
            bit got;
            int t;
            if (i == gap_at) begin
                set_src(s, 1'b0, '0, 1'b0);
                repeat (gap_len) begin @(posedge clk); #1; end
            end
            set_src(s, 1'b1, base + DATA_W'(i), last_end && (i == n - 1));
            got = 0;
            t   = 0;
            while (!got && t < 300) begin
                @(negedge clk);
                got = bus.in_ready[s] && bus.in_valid[s];
                t++;
            end
            if (!got) begin
                checks++; errors++;
                $display("FAIL accept_timeout: source %0d beat %0d got no in_ready, expected one", s + 1, i);
            end
            @(posedge clk); #1;
        end
        set_src(s, 1'b0, '0, 1'b0);
    endtask

    task automatic wait_acc(input int target);
        int t;
        t = 0;
        while (acc_count < target && t < 200) begin @(negedge clk); t++; end
        if (acc_count < target) begin
            checks++; errors++;
            $display("FAIL acc_timeout: got %0d accepts expected %0d", acc_count, target);
        end
    endtask

    initial begin
        logic [1:0]        exp_g[4];
        logic [DATA_W-1:0] exp_d[4];
        int                a0, o0;

        // reset state
        repeat (2) @(posedge clk);
        #2;
        chk("rst_out_valid", {136'd0, bus.out_valid}, 137'd0);
        chk("rst_busy",      {136'd0, bus.busy},      137'd0);
        chk("rst_mux_sel",   {135'd0, bus.mux_sel},   137'd0);
        chk("rst_in_ready",  {134'd0, bus.in_ready},  137'd0);
        chk("rst_out_data",  {1'b0, bus.out_data},    137'd0);
        @(posedge clk); #1 rst_n = 1;

        // all three request single-beat bursts
        out_log.delete(); grant_log.delete();
        d1 = 136'h11; d2 = 136'h22; d3 = 136'h33;
        {l1, l2, l3} = 3'b111; {v1, v2, v3} = 3'b111;
        repeat (8) @(posedge clk);
        #1 {v1, v2, v3} = 3'b000; {l1, l2, l3} = 3'b000;
        repeat (4) @(posedge clk); #1;
        exp_g[0] = 2'd0; exp_g[1] = 2'd1; exp_g[2] = 2'd2; exp_g[3] = 2'd0;
        exp_d[0] = 136'h11; exp_d[1] = 136'h22; exp_d[2] = 136'h33; exp_d[3] = 136'h11;
        chk("t1_grant_count", 137'(grant_log.size()), 137'd4);
        chk("t1_beat_count",  137'(out_log.size()),   137'd4);
        if (grant_log.size() >= 4 && out_log.size() >= 4) begin
            for (int i = 0; i < 4; i++) begin
                chk("t1_grant", {135'd0, grant_log[i]}, {135'd0, exp_g[i]});
                chk("t1_beat",  out_log[i], {1'b1, exp_d[i]});
            end
        end

        // source 2, four beats
        out_log.delete();
        send_burst(1, 4, 136'h1, 1, -1, 0);
        repeat (3) @(posedge clk); #1;
        chk("t2_beat_count", 137'(out_log.size()), 137'd4);
        if (out_log.size() == 4) begin
            for (int i = 0; i < 4; i++)
                chk("t2_beat", out_log[i], {i == 3, DATA_W'(i + 1)});
        end

        // source 3, twenty beats without last -> forced release at 16
        out_log.delete(); grant_log.delete();
        o0 = ov_count;
        send_burst(2, 20, 136'h100, 0, -1, 0);
        send_burst(2, 1, 136'h200, 1, -1, 0);
        repeat (3) @(posedge clk); #1;
        chk("t3_beat_count",  137'(out_log.size()),   137'd21);
        chk("t3_overruns",    137'(ov_count - o0),    137'd1);
        chk("t3_grant_count", 137'(grant_log.size()), 137'd2);
        if (out_log.size() == 21) begin
            chk("t3_beat15", out_log[14], {1'b0, 136'h10E});
            chk("t3_beat16", out_log[15], {1'b1, 136'h10F});
            chk("t3_beat17", out_log[16], {1'b0, 136'h110});
            chk("t3_beat21", out_log[20], {1'b1, 136'h200});
        end

        // downstream stall mid-burst
        out_log.delete();
        a0 = acc_count;
        fork
            send_burst(0, 6, 136'h40, 1, -1, 0);
            begin
                wait_acc(a0 + 2);
                @(posedge clk); #1 ordy = 0;
                repeat (3) begin
                    @(negedge clk);
                    chk("t4_stall_in_ready",  {134'd0, bus.in_ready},  137'd0);
                    chk("t4_stall_out_valid", {136'd0, bus.out_valid}, 137'd1);
                    @(posedge clk); #1;
                end
                ordy = 1;
            end
        join
        repeat (3) @(posedge clk); #1;
        chk("t4_beat_count", 137'(out_log.size()), 137'd6);
        if (out_log.size() == 6) begin
            for (int i = 0; i < 6; i++)
                chk("t4_beat", out_log[i], {i == 5, 136'h40 + DATA_W'(i)});
        end

        // source 1 pauses while source 2 waits
        out_log.delete(); grant_log.delete();
        fork
            send_burst(0, 3, 136'h50, 1, 1, 5);
            begin @(posedge clk); #1; send_burst(1, 2, 136'h60, 1, -1, 0); end
        join
        repeat (3) @(posedge clk); #1;
        chk("t5_grant_count", 137'(grant_log.size()), 137'd2);
        if (grant_log.size() == 2) begin
            chk("t5_grant0", {135'd0, grant_log[0]}, 137'd0);
            chk("t5_grant1", {135'd0, grant_log[1]}, 137'd1);
        end
        chk("t5_beat_count", 137'(out_log.size()), 137'd5);
        if (out_log.size() == 5) begin
            chk("t5_beat2", out_log[2], {1'b1, 136'h52});
            chk("t5_beat3", out_log[3], {1'b0, 136'h60});
        end

        // reset in the middle of a burst
        a0 = acc_count;
        d1 = 136'h70; l1 = 0; v1 = 1;
        wait_acc(a0 + 2);
        @(posedge clk); #3 rst_n = 0;
        #1;
        chk("t6_out_valid", {136'd0, bus.out_valid}, 137'd0);
        chk("t6_out_data",  {1'b0, bus.out_data},    137'd0);
        chk("t6_out_last",  {136'd0, bus.out_last},  137'd0);
        chk("t6_busy",      {136'd0, bus.busy},      137'd0);
        chk("t6_in_ready",  {134'd0, bus.in_ready},  137'd0);
        chk("t6_overrun",   {136'd0, bus.overrun},   137'd0);
        v1 = 0;
        repeat (2) @(posedge clk);
        #1 {l1, l2, l3} = 3'b111; {v1, v2, v3} = 3'b111;
        grant_log.delete();
        @(negedge clk); rst_n = 1;
        repeat (3) @(posedge clk);
        #1 {v1, v2, v3} = 3'b000;
        chk("t6_grants_seen", 137'(grant_log.size() > 0), 137'd1);
        if (grant_log.size() > 0) chk("t6_first_grant", {135'd0, grant_log[0]}, 137'd0);
        repeat (4) @(posedge clk); #1;

        // randomized traffic: frequent lasts, then rare lasts to reach the beat limit
        for (int c = 0; c < 4000; c++) begin
            int lim;
            lim = (c < 2000) ? 3 : 40;
            {v1, v2, v3} = 3'($urandom_range(0, 7));
            l1 = ($urandom_range(0, lim) == 0);
            l2 = ($urandom_range(0, lim) == 0);
            l3 = ($urandom_range(0, lim) == 0);
            d1 = {$urandom, $urandom, $urandom, $urandom, 8'($urandom)};
            d2 = {$urandom, $urandom, $urandom, $urandom, 8'($urandom)};
            d3 = {$urandom, $urandom, $urandom, $urandom, 8'($urandom)};
            ordy = ($urandom_range(0, 3) != 0);
            @(posedge clk); #1;
        end
        {v1, v2, v3} = 3'b000; ordy = 1;
        repeat (5) @(posedge clk); #1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
